// File: rtl/mem_access_unit.sv
// Memory-stage access unit: forwards one request at a time to a selected channel,
// waits for its acknowledge (or a timeout) and reports completion with a one-cycle DONE.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 48,
  parameter int unsigned ADDR_W  = 48,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     REQ_VALID,
  input  logic                     REQ_WE,
  input  logic [2:0]               REQ_CH,
  input  logic [ADDR_W-1:0]        REQ_ADDR,
  input  logic [DATA_W-1:0]        REQ_WDATA,
  output logic                     STALL,
  output logic                     DONE,
  output logic                     ERR,
  output logic [DATA_W-1:0]        RD_DATA,
  output logic [7:0]               ERR_CNT,
  output logic [N_CH-1:0]          CH_REQ,
  output logic                     CH_WE,
  output logic [ADDR_W-1:0]        CH_ADDR,
  output logic [DATA_W-1:0]        CH_WDATA,
  input  logic [N_CH-1:0]          CH_ACK,
  input  logic [N_CH*DATA_W-1:0]   CH_RDATA
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [N_CH-1:0]     ch_req_q, ch_req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CH_W-1:0]     sel_q, sel_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic                req_ok;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;
  logic [N_CH-1:0]     req_onehot;

  assign req_ok = (32'(REQ_CH) < N_CH);

  // Only the latched channel's ACK and data are ever looked at.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (sel_q == CH_W'(i)) begin
        ack_sel   = CH_ACK[i];
        rdata_sel = CH_RDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    req_onehot = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (REQ_CH == 3'(i)) req_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_req_d  = ch_req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_data_d = rd_data_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          if (req_ok) begin
            state_d  = StWait;
            cnt_d    = '0;
            ch_req_d = req_onehot;
            we_d     = REQ_WE;
            addr_d   = REQ_ADDR;
            wdata_d  = REQ_WDATA;
            sel_d    = REQ_CH[CH_W-1:0];
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      StWait: begin
        // ACK wins over a timeout landing on the same cycle.
        if (ack_sel) begin
          state_d  = StDone;
          ch_req_d = '0;
          done_d   = 1'b1;
          if (!we_q) rd_data_d = rdata_sel;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d  = StDone;
          ch_req_d = '0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          if (!we_q) rd_data_d = '0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ch_req_q  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_req_q  <= ch_req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // While reset is held the unit behaves as if idle.
  assign STALL = RESET ? (((state_q == StIdle) && REQ_VALID) || (state_q == StWait)) : REQ_VALID;

  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RD_DATA  = rd_data_q;
  assign ERR_CNT  = err_cnt_q;
  assign CH_REQ   = ch_req_q;
  assign CH_WE    = we_q;
  assign CH_ADDR  = addr_q;
  assign CH_WDATA = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_mem_access_unit;

  localparam int DW  = 48;
  localparam int AW  = 48;
  localparam int NCH = 4;
  localparam int TO  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid, req_we;
  logic [2:0]        req_ch;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic              stall, done, err;
  logic [DW-1:0]     rd_data;
  logic [7:0]        err_cnt;
  logic [NCH-1:0]    ch_req;
  logic              ch_we;
  logic [AW-1:0]     ch_addr;
  logic [DW-1:0]     ch_wdata;
  logic [NCH-1:0]    ch_ack;
  logic [NCH*DW-1:0] ch_rdata;

  mem_access_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .N_CH   (NCH),
    .TIMEOUT(TO)
  ) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .REQ_VALID(req_valid),
    .REQ_WE   (req_we),
    .REQ_CH   (req_ch),
    .REQ_ADDR (req_addr),
    .REQ_WDATA(req_wdata),
    .STALL    (stall),
    .DONE     (done),
    .ERR      (err),
    .RD_DATA  (rd_data),
    .ERR_CNT  (err_cnt),
    .CH_REQ   (ch_req),
    .CH_WE    (ch_we),
    .CH_ADDR  (ch_addr),
    .CH_WDATA (ch_wdata),
    .CH_ACK   (ch_ack),
    .CH_RDATA (ch_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdata(input int ch, input logic [DW-1:0] v);
    ch_rdata[ch*DW +: DW] = v;
  endtask

  // Transaction-level model: one outstanding access, age in wait cycles, a done flag.
  bit          m_valid = 0;
  bit          m_busy, m_done, m_err, m_fresh;
  int          m_ch, m_waited, m_errcnt;
  bit          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;

  task automatic m_finish(input bit e);
    m_busy = 0;
    m_done = 1;
    m_err  = e;
    if (e && m_errcnt < 255) m_errcnt++;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_valid = 1; m_busy = 0; m_done = 0; m_err = 0; m_rd = '0; m_errcnt = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_fresh = 1; m_waited = 0; m_ch = 0;
    end else if (!m_valid) begin
      m_valid = 0;
    end else if (m_done) begin
      m_done = 0;
      m_err  = 0;
    end else if (m_busy) begin
      m_waited++;
      if (ch_ack[m_ch]) begin
        m_finish(0);
        if (!m_we) m_rd = ch_rdata[m_ch*DW +: DW];
      end else if (m_waited == TO) begin
        m_finish(1);
        if (!m_we) m_rd = '0;
      end
    end else if (req_valid) begin
      if (int'(req_ch) < NCH) begin
        m_busy = 1; m_ch = int'(req_ch); m_we = req_we; m_addr = req_addr;
        m_wdata = req_wdata; m_waited = 0; m_fresh = 0;
      end else begin
        m_done = 1;
        m_err  = 1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: registered outputs after the edge, STALL against current inputs.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      logic [NCH-1:0] exp_req;
      bit             exp_stall;
      exp_req   = m_busy ? NCH'(1 << m_ch) : '0;
      exp_stall = !rst_n ? req_valid : (m_busy || (!m_done && req_valid));
      chk("m_done", 64'(done), 64'(m_done));
      chk("m_err", 64'(err), 64'(m_err));
      chk("m_rd_data", 64'(rd_data), 64'(m_rd));
      chk("m_err_cnt", 64'(err_cnt), 64'(m_errcnt));
      chk("m_ch_req", 64'(ch_req), 64'(exp_req));
      chk("m_stall", 64'(stall), 64'(exp_stall));
      if (m_busy || m_fresh) begin
        chk("m_ch_we", 64'(ch_we), 64'(m_we));
        chk("m_ch_addr", 64'(ch_addr), 64'(m_addr));
        chk("m_ch_wdata", 64'(ch_wdata), 64'(m_wdata));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    req_valid = 0; req_we = 0; req_ch = 0; req_addr = '0; req_wdata = '0;
    ch_ack = '0; ch_rdata = '0;
    rst_n = 0;
    tick(); tick();
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ch_req", 64'(ch_req), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    chk("rst_ch_addr", 64'(ch_addr), 64'(0));
    req_valid = 1; #1;
    chk("rst_stall", 64'(stall), 64'(1));
    req_valid = 0;
    rst_n = 1;
    tick();

    // Read from channel 2, ACK three cycles after CH_REQ rises.
    req_valid = 1; req_we = 0; req_ch = 2; req_addr = 48'h100;
    #1 chk("idle_stall", 64'(stall), 64'(1));
    tick();
    req_valid = 0;
    chk("rd_ch_req", 64'(ch_req), 64'(4'b0100));
    chk("rd_stall", 64'(stall), 64'(1));
    tick(); tick(); tick();
    ch_ack = 4'b0100; set_rdata(2, 48'hABCD);
    tick();
    ch_ack = '0;
    chk("rd_done", 64'(done), 64'(1));
    chk("rd_err", 64'(err), 64'(0));
    chk("rd_data", 64'(rd_data), 64'(48'hABCD));
    req_valid = 1; #1;
    chk("done_stall", 64'(stall), 64'(0));
    req_valid = 0;
    tick();

    // Write to channel 0 with immediate ACK.
    req_valid = 1; req_we = 1; req_ch = 0; req_addr = 48'h40; req_wdata = 48'h123456789ABC;
    tick();
    req_valid = 0;
    chk("wr_ch_we", 64'(ch_we), 64'(1));
    chk("wr_ch_wdata", 64'(ch_wdata), 64'(48'h123456789ABC));
    chk("wr_ch_req", 64'(ch_req), 64'(4'b0001));
    ch_ack = 4'b0001;
    tick();
    ch_ack = '0;
    chk("wr_done", 64'(done), 64'(1));
    chk("wr_rd_kept", 64'(rd_data), 64'(48'hABCD));
    tick();

    // Timeout on channel 1 while a stray ACK on channel 3 is present.
    req_valid = 1; req_we = 0; req_ch = 1;
    tick();
    req_valid = 0;
    ch_ack = 4'b1000;
    cnt = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (ch_req[1]) cnt++;
      if (done) seen = 1;
      else tick();
    end
    ch_ack = '0;
    chk("to_req_cycles", 64'(cnt), 64'(4));
    chk("to_done", 64'(seen), 64'(1));
    chk("to_err", 64'(err), 64'(1));
    chk("to_rd_zero", 64'(rd_data), 64'(0));
    chk("to_err_cnt", 64'(err_cnt), 64'(1));
    tick();

    // Channel 5 does not exist.
    req_valid = 1; req_ch = 5;
    tick();
    req_valid = 0;
    chk("inv_done", 64'(done), 64'(1));
    chk("inv_err", 64'(err), 64'(1));
    chk("inv_ch_req", 64'(ch_req), 64'(0));
    chk("inv_err_cnt", 64'(err_cnt), 64'(2));
    tick();

    // ACK arriving on the would-be timeout cycle.
    req_valid = 1; req_we = 0; req_ch = 3;
    tick();
    req_valid = 0;
    tick(); tick(); tick();
    ch_ack = 4'b1000; set_rdata(3, 48'h5555);
    tick();
    ch_ack = '0;
    chk("late_ack_done", 64'(done), 64'(1));
    chk("late_ack_err", 64'(err), 64'(0));
    chk("late_ack_rd", 64'(rd_data), 64'(48'h5555));
    tick();

    // Reset while waiting, then a late ACK.
    req_valid = 1; req_ch = 0;
    tick();
    req_valid = 0;
    chk("rw_ch_req", 64'(ch_req), 64'(4'b0001));
    rst_n = 0;
    tick();
    chk("rw_ch_req_drop", 64'(ch_req), 64'(0));
    chk("rw_no_done", 64'(done), 64'(0));
    rst_n = 1; ch_ack = 4'b0001;
    tick();
    chk("rw_ack_ignored", 64'(done), 64'(0));
    ch_ack = '0;
    tick();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      req_valid = $urandom_range(0, 1);
      req_we    = $urandom_range(0, 1);
      req_ch    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      ch_ack    = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) set_rdata(c, {$urandom, $urandom});
      tick();
    end

    // Saturate the error counter.
    rst_n = 1; ch_ack = '0; req_valid = 1; req_ch = 7;
    repeat (530) tick();
    req_valid = 0;
    tick(); tick();
    chk("sat_err_cnt", 64'(err_cnt), 64'(255));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
